data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single data-memory port (the address/data/wren/q bus decoded into general RAM,
//  image-in, image-out and button regions) between NUM_REQ requesters: CPU load/store unit and
//  the image DMA/filter engine. Issues at most one access per cycle and returns read data to
//  the requester that issued it, after the fixed synchronous-RAM latency.
//  Sits between the requesters and the memory manager's address_i/data_i/wren_i/data_o port.
// PARAMETERS
//  NUM_REQ   2   number of requesters; index 0 = CPU
//  AW        32  address width
//  DW        32  data width
//  RD_LAT    1   memory read latency in cycles (q valid RD_LAT cycles after address), 1..4
// PORTS
//  CLK          in   1            system clock, all logic on rising edge
//  RST          in   1            synchronous, active-high reset
//  req_i        in   NUM_REQ      per-requester access request, held until gnt_o
//  lock_i       in   NUM_REQ      requester keeps ownership after this grant (burst)
//  wren_i       in   NUM_REQ      1 = write, 0 = read
//  addr_i       in   NUM_REQ*AW   per-requester address, packed
//  wdata_i      in   NUM_REQ*DW   per-requester write data, packed
//  gnt_o        out  NUM_REQ      one-hot access accepted this cycle
//  rvalid_o     out  NUM_REQ      read data valid for that requester
//  rdata_o      out  DW           read data (shared; qualified by rvalid_o)
//  mem_addr_o   out  AW           to memory manager address_i
//  mem_data_o   out  DW           to memory manager data_i
//  mem_wren_o   out  1            to memory manager wren_i
//  mem_q_i      in   DW           from memory manager data_o
// BEHAVIOUR
//  - Reset: gnt_o=0, rvalid_o=0, rdata_o=0, mem_wren_o=0, mem_addr_o=0, mem_data_o=0;
//    state=IDLE, owner=0, rr pointer=0, read-tag pipeline cleared. Reset mid-burst drops
//    lock and any in-flight read; no rvalid_o is issued for it.
//  - Grant is combinational on req_i/state; mem_* driven combinationally from the granted
//    requester; gnt_o high in the same cycle the access hits the memory port. No grant ->
//    mem_wren_o=0, mem_addr_o/mem_data_o hold last value.
//  - FSM: IDLE -> pick winner among req_i; if winner's lock_i=1 -> LOCKED(owner=winner).
//    LOCKED: only owner may be granted; others stall; leaves to IDLE on the first owner grant
//    with lock_i=0, or on a cycle with req_i[owner]=0 and lock_i[owner]=0.
//  - Read tag: each granted read pushes {valid, id} into an RD_LAT-deep shift register;
//    at the tail rvalid_o[id]=1 and rdata_o=mem_q_i (registered if RD_LAT tap demands).
//    Back-to-back reads from alternating requesters return in issue order, one per cycle.
//  - Writes never produce rvalid_o. Write followed by read to same address next cycle returns
//    the new data (memory ordering is preserved; arbiter adds no reordering).
//  - Simultaneous req_i with no lock: winner per arbitration policy below; losers see gnt_o=0
//    and must hold req_i/addr_i/wdata_i stable.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: round-robin; pointer advances to (winner+1)%NUM_REQ after each
//    grant in IDLE; no requester waits more than NUM_REQ-1 grants.
//  Not defined: fixed priority, lowest index (CPU) wins; pointer logic absent.
// STRUCTURE
//  - Package data_mem_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t; typedef
//    struct packed {logic valid; logic [$clog2(NUM_REQ)-1:0] id;} rd_tag_t; region decode
//    constants for address[18:16] (REG_GENERAL=3'b000 .. REG_BUTTONS=3'b111).
//  - One sub-module: arb_pick (combinational winner select, priority or round-robin).
// TESTING
//  1. RST=1 two cycles with req_i=2'b11 -> gnt_o=0, rvalid_o=0, mem_wren_o=0 throughout.
//  2. CPU read addr 0x0000_0010 alone, mem holds 0xDEADBEEF -> gnt_o=01 cycle 0,
//     rvalid_o=01 with rdata_o=0xDEADBEEF at cycle RD_LAT.
//  3. req_i=11 continuously, no lock: RR build -> grants 01,10,01,10; priority build -> 01 always.
//  4. DMA writes 0x0001_0000..0x0001_0003 with lock_i=1 on first three -> gnt_o=10 four cycles
//     while CPU req held; CPU granted cycle 5; memory contents verified.
//  5. Alternating reads CPU@0x20, DMA@0x10020 back-to-back -> rvalid_o 01 then 10 in order,
//     data matches each address.
//  6. RST asserted one cycle after DMA read grant -> no rvalid_o for it; state IDLE after.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro used by this slice: ARB_ROUND_ROBIN_EN (round-robin arbitration
// instead of fixed priority).
package data_mem_pkg;

  // Arbiter ownership state: free for any requester, or held by a burst owner.
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Requester id field of a read tag; sized for up to 16 requesters.
  localparam int TAG_ID_W = 4;

  // One entry of the read-return pipeline.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

  // Region decode of address[18:16] as seen by the memory manager.
  localparam logic [2:0] REG_GENERAL = 3'b000;
  localparam logic [2:0] REG_IMG_IN  = 3'b001;
  localparam logic [2:0] REG_IMG_OUT = 3'b010;
  localparam logic [2:0] REG_BUTTONS = 3'b111;

endpackage

// File: rtl/data_mem_arbiter_arb_pick.sv
// Combinational winner select among active requests.
// ARB_ROUND_ROBIN_EN defined: search starts at ptr and wraps.
// Not defined: lowest index wins and there is no pointer input.
module arb_pick
  import data_mem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [IDW-1:0]     ptr,
`endif
  output logic               found,
  output logic [IDW-1:0]     winner
);

  int idx;

  // Scan from the farthest candidate to the nearest so the nearest active one wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = (int'(ptr) + k) % NUM_REQ;
`else
      idx = k;
`endif
      if (req[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one synchronous data-memory port between NUM_REQ requesters (index 0 = CPU).
// At most one access per cycle; grants are combinational so the granted access reaches
// the memory port in the same cycle. Read data is steered back to the issuing requester
// RD_LAT cycles later through a tag pipeline.
// Optional macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration in the idle state;
// without it the lowest-index requester always wins.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    lock_i,
  input  logic [NUM_REQ-1:0]    wren_i,
  input  logic [NUM_REQ*AW-1:0] addr_i,
  input  logic [NUM_REQ*DW-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rvalid_o,
  output logic [DW-1:0]         rdata_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DW-1:0]         mem_data_o,
  output logic                  mem_wren_o,
  input  logic [DW-1:0]         mem_q_i
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t     state_reg, state_next;
  logic [IDW-1:0] owner_reg, owner_next;
  logic [AW-1:0]  addr_hold_reg;
  logic [DW-1:0]  data_hold_reg;
  rd_tag_t        tag_pipe_reg [RD_LAT];
  rd_tag_t        tag_in;
  rd_tag_t        tag_tail;

  logic [AW-1:0]  addr_arr  [NUM_REQ];
  logic [DW-1:0]  wdata_arr [NUM_REQ];

  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;

  // Unpack the per-requester address and write-data buses.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr_i[gi*AW +: AW];
      assign wdata_arr[gi] = wdata_i[gi*DW +: DW];
    end
  endgenerate

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;

  arb_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req    (req_i),
    .ptr    (rr_ptr_reg),
    .found  (pick_found),
    .winner (pick_id)
  );

  // Pointer moves just past the winner of every idle-state grant.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (gnt_any && (state_reg == ARB_IDLE)) begin
      rr_ptr_next = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK) begin
    if (RST) rr_ptr_reg <= '0;
    else     rr_ptr_reg <= rr_ptr_next;
  end
`else
  arb_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req    (req_i),
    .found  (pick_found),
    .winner (pick_id)
  );
`endif

  // Grant decision and ownership FSM; nothing is granted while reset is held.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    gnt_any    = 1'b0;
    gnt_id     = owner_reg;
    if (!RST) begin
      case (state_reg)
        ARB_IDLE: begin
          if (pick_found) begin
            gnt_any = 1'b1;
            gnt_id  = pick_id;
            if (lock_i[pick_id]) begin
              state_next = ARB_LOCKED;
              owner_next = pick_id;
            end
          end
        end
        ARB_LOCKED: begin
          if (req_i[owner_reg]) begin
            gnt_any = 1'b1;
            gnt_id  = owner_reg;
            if (!lock_i[owner_reg]) state_next = ARB_IDLE;
          end else if (!lock_i[owner_reg]) begin
            state_next = ARB_IDLE;
          end
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  // FSM state and burst owner registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ARB_IDLE;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign gnt_o[gi] = gnt_any && (gnt_id == IDW'(gi));
    end
  endgenerate

  // Memory port follows the granted requester; address/data park on the last access.
  assign mem_wren_o = gnt_any && wren_i[gnt_id];
  assign mem_addr_o = gnt_any ? addr_arr[gnt_id]  : addr_hold_reg;
  assign mem_data_o = gnt_any ? wdata_arr[gnt_id] : data_hold_reg;

  // Remember the last driven address/data so the bus is quiet between accesses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
    end else if (gnt_any) begin
      addr_hold_reg <= addr_arr[gnt_id];
      data_hold_reg <= wdata_arr[gnt_id];
    end
  end

  // A granted read enters the tag pipeline; writes enter as bubbles.
  assign tag_in.valid = gnt_any && !wren_i[gnt_id];
  assign tag_in.id    = TAG_ID_W'(gnt_id);

  // Tag shift register matching the memory read latency; reset discards in-flight reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe_reg[i] <= '0;
    end else begin
      tag_pipe_reg[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_pipe_reg[i] <= tag_pipe_reg[i-1];
    end
  end

  assign tag_tail = tag_pipe_reg[RD_LAT-1];

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
      assign rvalid_o[gi] = !RST && tag_tail.valid && (tag_tail.id == TAG_ID_W'(gi));
    end
  endgenerate

  assign rdata_o = (!RST && tag_tail.valid) ? mem_q_i : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, hand-written corner
// sequences (reset, single read, locked burst, ordering, reset mid-read) and a randomized
// run against a transaction-level reference model. Expectations follow the
// ARB_ROUND_ROBIN_EN build option when it is defined.
module tb_data_mem_arbiter;

  localparam int TB_RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  b_req, b_lock, b_wren;
  logic [31:0] b_addr  [2];
  logic [31:0] b_wdata [2];
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o, mem_addr_o, mem_data_o, mem_q_i;
  logic        mem_wren_o;

  always #5 clk = ~clk;

  data_mem_arbiter #(.NUM_REQ(2), .AW(32), .DW(32), .RD_LAT(TB_RD_LAT)) dut (
    .CLK        (clk),
    .RST        (rst),
    .req_i      (b_req),
    .lock_i     (b_lock),
    .wren_i     (b_wren),
    .addr_i     ({b_addr[1], b_addr[0]}),
    .wdata_i    ({b_wdata[1], b_wdata[0]}),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_wren_o (mem_wren_o),
    .mem_q_i    (mem_q_i)
  );

  // ---------------- memory model: synchronous RAM, TB_RD_LAT read latency ----------------
  logic [31:0] ram    [512];
  logic [31:0] shadow [512];
  logic [31:0] q_pipe [TB_RD_LAT];
  bit          ram_ready = 1'b0;

  function automatic logic [8:0] mi(input logic [31:0] a);
    return {a[16], a[7:0]};
  endfunction

  function automatic logic [31:0] pat(input int i);
    if (i == 32'h010) return 32'hDEADBEEF;
    return 32'hA5C30000 + i;
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 512; i++) ram[i] <= pat(i);
      ram_ready <= 1'b1;
    end else if (mem_wren_o) begin
      ram[mi(mem_addr_o)] <= mem_data_o;
    end
    q_pipe[0] <= ram[mi(mem_addr_o)];
    for (int i = 1; i < TB_RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q_i = q_pipe[TB_RD_LAT-1];

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0]  s_gnt, s_rvalid;
  logic [31:0] s_rdata, s_addr, s_data;
  logic        s_wren;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Sample outputs mid-cycle, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    s_gnt    = gnt_o;
    s_rvalid = rvalid_o;
    s_rdata  = rdata_o;
    s_addr   = mem_addr_o;
    s_data   = mem_data_o;
    s_wren   = mem_wren_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b_req = 2'b00; b_lock = 2'b00; b_wren = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input int r, input logic wr, input logic lk,
                       input logic [31:0] a, input logic [31:0] d);
    b_req[r] = 1'b1; b_wren[r] = wr; b_lock[r] = lk; b_addr[r] = a; b_wdata[r] = d;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  req, lock, wren;
    logic [31:0] a1, d1;
    logic [1:0]  exp_gnt;
    logic        exp_wren;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t tbl [9];

  // ---------------- random-phase reference model state ----------------
  typedef struct { int id; logic [31:0] data; int due; } pend_t;
  pend_t       pq[$];
  bit          m_locked;
  int          m_owner, m_ptr;
  logic [31:0] m_last_addr;
  bit          e_any;
  int          e_id;
  logic [1:0]  e_gnt, e_rv;
  logic [31:0] e_rd;
  logic [31:0] ra;

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int r = 0; r < 2; r++) begin b_addr[r] = '0; b_wdata[r] = '0; end
    @(posedge clk); #1;

    // Reset held with both requesting: no grant, no read return, no write.
    b_req = 2'b11;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("rst%0d_gnt", c), s_gnt, 2'b00);
      chk($sformatf("rst%0d_rvalid", c), s_rvalid, 2'b00);
      chk($sformatf("rst%0d_wren", c), s_wren, 1'b0);
    end
    rst = 1'b0;
    idle_inputs();
    step();
    chk("post_rst_addr", s_addr, 32'h0);

    // Single CPU read.
    drive(0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    step();
    chk("cpu_rd_gnt", s_gnt, 2'b01);
    chk("cpu_rd_addr", s_addr, 32'h10);
    idle_inputs();
    for (int k = 1; k < TB_RD_LAT; k++) begin
      step();
      chk("cpu_rd_early_rvalid", s_rvalid, 2'b00);
    end
    step();
    chk("cpu_rd_rvalid", s_rvalid, 2'b01);
    chk("cpu_rd_rdata", s_rdata, 32'hDEADBEEF);

    // Table: contention without lock, then a locked DMA write burst.
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    tbl[0] = '{2'b11, 2'b00, 2'b00, 32'h10030, 32'h0, 2'b01, 1'b0, 32'h30};
    tbl[1] = '{2'b11, 2'b00, 2'b00, 32'h10030, 32'h0, 2'b10, 1'b0, 32'h10030};
    tbl[2] = '{2'b11, 2'b00, 2'b00, 32'h10030, 32'h0, 2'b01, 1'b0, 32'h30};
    tbl[3] = '{2'b11, 2'b00, 2'b00, 32'h10030, 32'h0, 2'b10, 1'b0, 32'h10030};
`else
    for (int v = 0; v < 4; v++) tbl[v] = '{2'b11, 2'b00, 2'b00, 32'h10030, 32'h0, 2'b01, 1'b0, 32'h30};
`endif
    tbl[4] = '{2'b10, 2'b10, 2'b10, 32'h10000, 32'h11110000, 2'b10, 1'b1, 32'h10000};
    tbl[5] = '{2'b11, 2'b10, 2'b10, 32'h10001, 32'h11110001, 2'b10, 1'b1, 32'h10001};
    tbl[6] = '{2'b11, 2'b10, 2'b10, 32'h10002, 32'h11110002, 2'b10, 1'b1, 32'h10002};
    tbl[7] = '{2'b11, 2'b00, 2'b10, 32'h10003, 32'h11110003, 2'b10, 1'b1, 32'h10003};
    tbl[8] = '{2'b11, 2'b00, 2'b00, 32'h10000, 32'h0,        2'b01, 1'b0, 32'h30};
    for (int v = 0; v < 9; v++) begin
      b_req = tbl[v].req; b_lock = tbl[v].lock; b_wren = tbl[v].wren;
      b_addr[0] = 32'h30; b_wdata[0] = 32'h0;
      b_addr[1] = tbl[v].a1; b_wdata[1] = tbl[v].d1;
      step();
      chk($sformatf("tbl%0d_gnt", v), s_gnt, tbl[v].exp_gnt);
      chk($sformatf("tbl%0d_wren", v), s_wren, tbl[v].exp_wren);
      chk($sformatf("tbl%0d_addr", v), s_addr, tbl[v].exp_addr);
    end
    idle_inputs();
    step();
    for (int k = 0; k < 4; k++)
      chk($sformatf("burst_mem%0d", k), ram[mi(32'h10000 + k)], 32'h11110000 + k);

    // Back-to-back alternating reads return in issue order.
    drive(0, 1'b0, 1'b0, 32'h20, 32'h0);
    step();
    chk("alt_cpu_gnt", s_gnt, 2'b01);
    idle_inputs();
    drive(1, 1'b0, 1'b0, 32'h10020, 32'h0);
    step();
    chk("alt_dma_gnt", s_gnt, 2'b10);
    chk("alt_rv0", s_rvalid, 2'b01);
    chk("alt_rd0", s_rdata, pat(32'h020));
    idle_inputs();
    step();
    chk("alt_rv1", s_rvalid, 2'b10);
    chk("alt_rd1", s_rdata, pat(32'h120));

    // Write then read of the same address on the next cycle.
    drive(0, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D);
    step();
    chk("wr_gnt", s_gnt, 2'b01);
    chk("wr_wren", s_wren, 1'b1);
    chk("wr_no_rvalid", s_rvalid, 2'b00);
    drive(0, 1'b0, 1'b0, 32'h40, 32'h0);
    step();
    chk("raw_rd_no_early", s_rvalid, 2'b00);
    idle_inputs();
    step();
    chk("raw_rvalid", s_rvalid, 2'b01);
    chk("raw_rdata", s_rdata, 32'hCAFEF00D);

    // Reset one cycle after a locked DMA read grant drops the read and the lock.
    drive(1, 1'b0, 1'b1, 32'h10010, 32'h0);
    step();
    chk("rstmid_gnt", s_gnt, 2'b10);
    rst = 1'b1;
    idle_inputs();
    step();
    chk("rstmid_rvalid", s_rvalid, 2'b00);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
    step();
    chk("rstmid_cpu_gnt", s_gnt, 2'b01);
    chk("rstmid_rvalid2", s_rvalid, 2'b00);
    idle_inputs();
    step();
    chk("rstmid_cpu_rvalid", s_rvalid, 2'b01);
    chk("rstmid_cpu_rdata", s_rdata, 32'hDEADBEEF);

    // Randomized traffic against the reference model.
    do_reset();
    shadow = ram;
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_last_addr = 32'h0;
    pq.delete();
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!b_req[r] && ($urandom_range(0, 2) != 0)) begin
          ra = 32'($urandom_range(0, 255));
          ra[16] = 1'($urandom_range(0, 1));
          drive(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ra, $urandom);
        end
      end
      e_any = 1'b0; e_id = 0;
      if (m_locked) begin
        if (b_req[m_owner]) begin e_any = 1'b1; e_id = m_owner; end
      end else begin
        for (int k = 0; k < 2; k++) begin
          int r;
`ifdef ARB_ROUND_ROBIN_EN
          r = (m_ptr + k) % 2;
`else
          r = k;
`endif
          if (!e_any && b_req[r]) begin e_any = 1'b1; e_id = r; end
        end
      end
      e_gnt = e_any ? (2'b01 << e_id) : 2'b00;
      e_rv = 2'b00; e_rd = 32'h0;
      if ((pq.size() > 0) && (pq[0].due == c)) begin
        e_rv = 2'b01 << pq[0].id;
        e_rd = pq[0].data;
        void'(pq.pop_front());
      end
      step();
      chk($sformatf("rnd%0d_gnt", c), s_gnt, e_gnt);
      if (e_any) begin
        chk($sformatf("rnd%0d_wren", c), s_wren, b_wren[e_id]);
        chk($sformatf("rnd%0d_addr", c), s_addr, b_addr[e_id]);
        if (b_wren[e_id]) chk($sformatf("rnd%0d_wdata", c), s_data, b_wdata[e_id]);
      end else begin
        chk($sformatf("rnd%0d_idle_wren", c), s_wren, 1'b0);
        chk($sformatf("rnd%0d_hold_addr", c), s_addr, m_last_addr);
      end
      chk($sformatf("rnd%0d_rvalid", c), s_rvalid, e_rv);
      if (e_rv != 2'b00) chk($sformatf("rnd%0d_rdata", c), s_rdata, e_rd);

      if (e_any) begin
        m_last_addr = b_addr[e_id];
        if (b_wren[e_id]) shadow[mi(b_addr[e_id])] = b_wdata[e_id];
        else pq.push_back('{e_id, shadow[mi(b_addr[e_id])], c + TB_RD_LAT});
      end
      if (!m_locked) begin
        if (e_any) begin
          m_ptr = (e_id + 1) % 2;
          if (b_lock[e_id]) begin m_locked = 1'b1; m_owner = e_id; end
        end
      end else if (!b_lock[m_owner]) begin
        m_locked = 1'b0;
      end
      if (e_any) begin b_req[e_id] = 1'b0; b_lock[e_id] = 1'b0; end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
